// File: rtl/sl_pkg.sv
// sl_pkg: definitions shared by the SL transmitter, the SL receiver and the APB bridge.
//   sl_state_e             - line sequencer state encoding
//   CFG_*                  - bit positions in the per-word config register
//   STAT_*                 - bit positions in the status register
//   MIN_BITS / MAX_BITS    - legal data-bit quantity range
//   odd_parity(data, n)    - parity bit that makes the count of ones in data[n-1:0]+p odd
package sl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_BIT  = 3'd1,
    ST_PAR  = 3'd2,
    ST_STOP = 3'd3,
    ST_GAP  = 3'd4
  } sl_state_e;

  // Config register fields: PCE is the parity-enable bit, BQ is the bit quantity.
  localparam int CFG_PCE = 0;
  localparam int CFG_BQL = 1;
  localparam int CFG_BQH = 6;

  // Status register bits.
  localparam int STAT_TX_READY = 0;
  localparam int STAT_BUSY     = 1;
  localparam int STAT_DONE     = 2;
  localparam int STAT_LEN_ERR  = 3;

  localparam int MIN_BITS = 8;
  localparam int MAX_BITS = 32;

  function automatic logic odd_parity(input logic [31:0] data, input logic [5:0] n);
    logic p;
    p = 1'b0;
    for (int i = 0; i < 32; i++) begin
      if (i < int'(n)) p = p ^ data[i];
    end
    return ~p;
  endfunction

endpackage

// File: rtl/sl_bit_timer.sv
// sl_bit_timer: bit-period timer for the SL line.
//   k counts 0..BIT_CLKS-1 and wraps; clr forces the next k to 0 (holds it at 0 while idle).
//   Strobes describing the current k and the next k are provided so that a user can
//   register its line drive from next-cycle values without a combinational output path.
// Ports:
//   clk, rst_n       clock, synchronous active-low reset
//   clr              next k = 0
//   bit_end_o        current k == BIT_CLKS-1
//   pulse_low_nxt_o  next k < PULSE_CLKS (line should be low next cycle)
//   bit_end_nxt_o    next k == BIT_CLKS-1
module sl_bit_timer #(
  parameter int BIT_CLKS   = 16,
  parameter int PULSE_CLKS = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic bit_end_o,
  output logic pulse_low_nxt_o,
  output logic bit_end_nxt_o
);

  localparam int KW = $clog2(BIT_CLKS);
  localparam logic [KW-1:0] K_LAST  = KW'(BIT_CLKS - 1);
  localparam logic [KW-1:0] K_PULSE = KW'(PULSE_CLKS);

  logic [KW-1:0] k_q;
  logic [KW-1:0] k_d;

  always_comb begin
    k_d = k_q + 1'b1;
    if (clr || (k_q == K_LAST)) k_d = '0;
  end

  assign bit_end_o       = (k_q == K_LAST);
  assign pulse_low_nxt_o = (k_d < K_PULSE);
  assign bit_end_nxt_o   = (k_d == K_LAST);

  always_ff @(posedge clk) begin
    if (!rst_n) k_q <= '0;
    else        k_q <= k_d;
  end

endmodule

// File: rtl/sl_tx_sequencer.sv
// sl_tx_sequencer: SL two-wire serial transmitter.
//   Serialises 32-bit words LSB first as low pulses on SL0 (bit 0) / SL1 (bit 1),
//   followed by an optional odd-parity bit, a stop symbol (both lines low) and an
//   inter-word gap. A one-word holding buffer lets the next word be queued mid-word.
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   tx_en                      1 = new words may start
//   cfg_bit_cnt, cfg_parity_en per-word config, captured with the word
//   tx_data, tx_valid          word offer
//   tx_ready                   holding buffer empty (registered)
//   sl0_o, sl1_o               line drives, idle high, active low (registered)
//   busy                       word on the line, gap included
//   done                       1-cycle pulse on the last cycle of STOP
//   len_err                    1-cycle pulse: an accepted word had an illegal bit count
//   dbg_state                  current sequencer state
// Handshake: a word transfers on a rising clk edge where tx_valid=1 and tx_ready=1;
//   tx_ready does not depend on tx_valid, and an offer may be withdrawn freely.
module sl_tx_sequencer
  import sl_pkg::*;
#(
  parameter int BIT_CLKS   = 16,
  parameter int PULSE_CLKS = 8,
  parameter int GAP_BITS   = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        tx_en,
  input  logic [5:0]  cfg_bit_cnt,
  input  logic        cfg_parity_en,
  input  logic [31:0] tx_data,
  input  logic        tx_valid,
  output logic        tx_ready,
  output logic        sl0_o,
  output logic        sl1_o,
  output logic        busy,
  output logic        done,
  output logic        len_err,
  output sl_state_e   dbg_state
);

  localparam int GAP_CYC = GAP_BITS * BIT_CLKS;
  localparam int GW      = (GAP_CYC > 2) ? $clog2(GAP_CYC) : 1;
  localparam logic [GW-1:0] GAP_LAST = (GAP_CYC > 0) ? GW'(GAP_CYC - 1) : '0;

  sl_state_e   state_q, state_d;
  logic [31:0] shift_q, shift_d;
  logic [5:0]  bit_idx_q, bit_idx_d;
  logic [5:0]  bit_cnt_q, bit_cnt_d;
  logic        par_en_q, par_en_d;
  logic        par_bit_q, par_bit_d;
  logic [GW-1:0] gap_cnt_q, gap_cnt_d;

  logic        hold_full_q, hold_full_d;
  logic [31:0] hold_data_q, hold_data_d;
  logic [5:0]  hold_cnt_q, hold_cnt_d;
  logic        hold_par_q, hold_par_d;

  logic        bad_q, bad_d;
  logic        len_err_q, len_err_d;
  logic        tx_ready_q, tx_ready_d;
  logic        sl0_q, sl0_d;
  logic        sl1_q, sl1_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  logic        load;
  logic        can_start;
  logic        accept;
  logic        len_ok;
  logic        timer_clr;
  logic        bit_end;
  logic        pulse_low_nxt;
  logic        bit_end_nxt;

  // k is held at 0 while idle and restarted whenever a word is loaded, so each word
  // starts with a full pulse regardless of where the timer was during the gap.
  assign timer_clr = (state_d == ST_IDLE) || load;

  sl_bit_timer #(
    .BIT_CLKS  (BIT_CLKS),
    .PULSE_CLKS(PULSE_CLKS)
  ) u_timer (
    .clk            (clk),
    .rst_n          (rst_n),
    .clr            (timer_clr),
    .bit_end_o      (bit_end),
    .pulse_low_nxt_o(pulse_low_nxt),
    .bit_end_nxt_o  (bit_end_nxt)
  );

  assign can_start = hold_full_q && tx_en;
  assign accept    = tx_valid && tx_ready_q;
  assign len_ok    = (cfg_bit_cnt >= 6'(MIN_BITS)) && (cfg_bit_cnt <= 6'(MAX_BITS));

  // Sequencer next state. A held word is loaded straight from the end of GAP (or STOP
  // when there is no gap) so back-to-back words see exactly the gap and nothing more.
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_idx_d = bit_idx_q;
    bit_cnt_d = bit_cnt_q;
    par_en_d  = par_en_q;
    par_bit_d = par_bit_q;
    gap_cnt_d = gap_cnt_q;
    load      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (can_start) load = 1'b1;
      end
      ST_BIT: begin
        if (bit_end) begin
          shift_d = shift_q >> 1;
          if (bit_idx_q == bit_cnt_q - 6'd1) begin
            state_d = par_en_q ? ST_PAR : ST_STOP;
          end else begin
            bit_idx_d = bit_idx_q + 6'd1;
          end
        end
      end
      ST_PAR: begin
        if (bit_end) state_d = ST_STOP;
      end
      ST_STOP: begin
        if (bit_end) begin
          if (GAP_CYC == 0) begin
            if (can_start) load = 1'b1;
            else           state_d = ST_IDLE;
          end else begin
            state_d   = ST_GAP;
            gap_cnt_d = '0;
          end
        end
      end
      ST_GAP: begin
        if (gap_cnt_q == GAP_LAST) begin
          if (can_start) load = 1'b1;
          else           state_d = ST_IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (load) begin
      state_d   = ST_BIT;
      shift_d   = hold_data_q;
      bit_idx_d = '0;
      bit_cnt_d = hold_cnt_q;
      par_en_d  = hold_par_q;
      par_bit_d = odd_parity(hold_data_q, hold_cnt_q);
    end
  end

  // Holding buffer. Load and accept never coincide: tx_ready is low while the buffer is full.
  always_comb begin
    hold_full_d = hold_full_q;
    hold_data_d = hold_data_q;
    hold_cnt_d  = hold_cnt_q;
    hold_par_d  = hold_par_q;
    bad_d       = 1'b0;
    if (load) hold_full_d = 1'b0;
    if (accept) begin
      if (len_ok) begin
        hold_full_d = 1'b1;
        hold_data_d = tx_data;
        hold_cnt_d  = cfg_bit_cnt;
        hold_par_d  = cfg_parity_en;
      end else begin
        bad_d = 1'b1;
      end
    end
  end

  // Registered outputs, computed from next-cycle state and next-cycle k.
  always_comb begin
    sl0_d      = 1'b1;
    sl1_d      = 1'b1;
    busy_d     = (state_d != ST_IDLE);
    done_d     = (state_d == ST_STOP) && bit_end_nxt;
    tx_ready_d = !hold_full_d;
    len_err_d  = bad_q;
    if (pulse_low_nxt) begin
      case (state_d)
        ST_BIT: begin
          if (shift_d[0]) sl1_d = 1'b0;
          else            sl0_d = 1'b0;
        end
        ST_PAR: begin
          if (par_bit_d) sl1_d = 1'b0;
          else           sl0_d = 1'b0;
        end
        ST_STOP: begin
          sl0_d = 1'b0;
          sl1_d = 1'b0;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      shift_q     <= '0;
      bit_idx_q   <= '0;
      bit_cnt_q   <= '0;
      par_en_q    <= 1'b0;
      par_bit_q   <= 1'b0;
      gap_cnt_q   <= '0;
      hold_full_q <= 1'b0;
      hold_data_q <= '0;
      hold_cnt_q  <= '0;
      hold_par_q  <= 1'b0;
      bad_q       <= 1'b0;
      len_err_q   <= 1'b0;
      tx_ready_q  <= 1'b1;
      sl0_q       <= 1'b1;
      sl1_q       <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      bit_idx_q   <= bit_idx_d;
      bit_cnt_q   <= bit_cnt_d;
      par_en_q    <= par_en_d;
      par_bit_q   <= par_bit_d;
      gap_cnt_q   <= gap_cnt_d;
      hold_full_q <= hold_full_d;
      hold_data_q <= hold_data_d;
      hold_cnt_q  <= hold_cnt_d;
      hold_par_q  <= hold_par_d;
      bad_q       <= bad_d;
      len_err_q   <= len_err_d;
      tx_ready_q  <= tx_ready_d;
      sl0_q       <= sl0_d;
      sl1_q       <= sl1_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign tx_ready  = tx_ready_q;
  assign sl0_o     = sl0_q;
  assign sl1_o     = sl1_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign len_err   = len_err_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_sl_tx_sequencer.sv
module tb_sl_tx_sequencer;
  import sl_pkg::*;

  localparam int BIT_CLKS   = 16;
  localparam int PULSE_CLKS = 8;
  localparam int GAP_BITS   = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        tx_en = 1'b0;
  logic [5:0]  cfg_bit_cnt = 6'd8;
  logic        cfg_parity_en = 1'b0;
  logic [31:0] tx_data = '0;
  logic        tx_valid = 1'b0;
  logic        tx_ready, sl0_o, sl1_o, busy, done, len_err;
  sl_state_e   dbg_state;

  int checks = 0;
  int errors = 0;

  // Per-cycle line trace entries: {sl0, sl1, busy, done}
  logic [3:0] exp_q[$];
  logic [3:0] got_q[$];

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  sl_tx_sequencer #(
    .BIT_CLKS  (BIT_CLKS),
    .PULSE_CLKS(PULSE_CLKS),
    .GAP_BITS  (GAP_BITS)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .tx_en        (tx_en),
    .cfg_bit_cnt  (cfg_bit_cnt),
    .cfg_parity_en(cfg_parity_en),
    .tx_data      (tx_data),
    .tx_valid     (tx_valid),
    .tx_ready     (tx_ready),
    .sl0_o        (sl0_o),
    .sl1_o        (sl1_o),
    .busy         (busy),
    .done         (done),
    .len_err      (len_err),
    .dbg_state    (dbg_state)
  );

  // ---------------- reference model ----------------
  // A word is a list of symbols (0, 1, or 2 = stop), each one bit period long with the
  // symbol's line(s) low for the first PULSE_CLKS cycles, followed by the idle gap.
  function automatic void model_word(input logic [31:0] d, input int n, input bit p);
    int sym[$];
    int ones;
    bit low;
    ones = 0;
    for (int i = 0; i < n; i++) begin
      sym.push_back(int'(d[i]));
      ones += int'(d[i]);
    end
    if (p) sym.push_back((ones % 2 == 0) ? 1 : 0);
    sym.push_back(2);
    foreach (sym[s]) begin
      for (int c = 0; c < BIT_CLKS; c++) begin
        low = (c < PULSE_CLKS);
        exp_q.push_back({!(low && sym[s] != 1), !(low && sym[s] != 0), 1'b1,
                         (sym[s] == 2 && c == BIT_CLKS - 1)});
      end
    end
    repeat (GAP_BITS * BIT_CLKS) exp_q.push_back(4'b1110);
  endfunction

  // ---------------- driver tasks ----------------
  task automatic send_word(input logic [31:0] d, input logic [5:0] n, input logic p);
    int t;
    t = 0;
    @(negedge clk);
    while (tx_ready !== 1'b1 && t < 2000) begin
      @(negedge clk);
      t++;
    end
    checks++;
    if (tx_ready !== 1'b1) begin
      errors++;
      $display("FAIL send_ready: tx_ready=%b, required 1 within 2000 cycles", tx_ready);
    end
    tx_data       = d;
    cfg_bit_cnt   = n;
    cfg_parity_en = p;
    tx_valid      = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  // Records the line trace from the first busy cycle until busy drops.
  task automatic capture();
    int t;
    t = 0;
    got_q.delete();
    while (busy !== 1'b1 && t < 400) begin
      @(negedge clk);
      t++;
    end
    while (busy === 1'b1 && got_q.size() < 4000) begin
      got_q.push_back({sl0_o, sl1_o, busy, done});
      @(negedge clk);
    end
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while (busy !== 1'b0 && t < 2000) begin
      @(negedge clk);
      t++;
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (sl0_o !== 1'b1) begin errors++; $display("FAIL reset_sl0: got %b, required 1", sl0_o); end
    checks++; if (sl1_o !== 1'b1) begin errors++; $display("FAIL reset_sl1: got %b, required 1", sl1_o); end
    checks++; if (tx_ready !== 1'b1) begin errors++; $display("FAIL reset_tx_ready: got %b, required 1", tx_ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b, required 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b, required 0", done); end
    checks++; if (len_err !== 1'b0) begin errors++; $display("FAIL reset_len_err: got %b, required 0", len_err); end
    checks++; if (dbg_state !== ST_IDLE) begin errors++; $display("FAIL reset_state: got %0d, required %0d", dbg_state, ST_IDLE); end
    rst_n = 1'b1;
    tx_en = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_latency();
    send_word(32'h0000_00A5, 6'd8, 1'b0);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL lat_busy_e: got %b, required 0", busy); end
    checks++; if (tx_ready !== 1'b0) begin errors++; $display("FAIL lat_ready_e: got %b, required 0", tx_ready); end
    @(negedge clk);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL lat_busy_e1: got %b, required 1", busy); end
    checks++; if ({sl0_o, sl1_o} !== 2'b10) begin errors++; $display("FAIL lat_first_pulse: got sl0,sl1=%b, required 10", {sl0_o, sl1_o}); end
    checks++; if (tx_ready !== 1'b1) begin errors++; $display("FAIL lat_ready_e1: got %b, required 1", tx_ready); end
    wait_idle();
    @(negedge clk);
  endtask

  task automatic test_fixed_words();
    logic [31:0] w_data [3];
    int          w_cnt  [3];
    bit          w_par  [3];
    w_data = '{32'h0000_00A5, 32'h0000_00A5, 32'hFFFF_0000};
    w_cnt  = '{8, 8, 32};
    w_par  = '{1'b0, 1'b1, 1'b1};
    for (int w = 0; w < 3; w++) begin
      exp_q.delete();
      model_word(w_data[w], w_cnt[w], w_par[w]);
      fork
        capture();
        send_word(w_data[w], 6'(w_cnt[w]), w_par[w]);
      join
      checks++;
      if (got_q.size() !== exp_q.size()) begin
        errors++;
        $display("FAIL fixed%0d_len: got %0d busy cycles, required %0d", w, got_q.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
        checks++;
        if (got_q[i] !== exp_q[i]) begin
          errors++;
          $display("FAIL fixed%0d_trace: cycle %0d got {sl0,sl1,busy,done}=%b, required %b", w, i, got_q[i], exp_q[i]);
          break;
        end
      end
    end
  endtask

  task automatic test_len_err();
    int bad_cnt [2];
    int quiet_viol;
    bad_cnt = '{5, 33};
    for (int b = 0; b < 2; b++) begin
      send_word($urandom, 6'(bad_cnt[b]), 1'b0);
      checks++; if (tx_ready !== 1'b1) begin errors++; $display("FAIL len%0d_ready: got %b, required 1", bad_cnt[b], tx_ready); end
      checks++; if (len_err !== 1'b0) begin errors++; $display("FAIL len%0d_early: got %b, required 0", bad_cnt[b], len_err); end
      @(negedge clk);
      checks++; if (len_err !== 1'b1) begin errors++; $display("FAIL len%0d_pulse: got %b, required 1", bad_cnt[b], len_err); end
      @(negedge clk);
      checks++; if (len_err !== 1'b0) begin errors++; $display("FAIL len%0d_width: got %b, required 0", bad_cnt[b], len_err); end
      quiet_viol = 0;
      repeat (300) begin
        if (sl0_o !== 1'b1 || sl1_o !== 1'b1 || busy !== 1'b0 || tx_ready !== 1'b1) quiet_viol++;
        @(negedge clk);
      end
      checks++;
      if (quiet_viol !== 0) begin errors++; $display("FAIL len%0d_quiet: got %0d active cycles, required 0", bad_cnt[b], quiet_viol); end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] d1, d2;
    int n1, n2, t;
    bit p1, p2;
    d1 = $urandom; d2 = $urandom;
    n1 = $urandom_range(8, 32); n2 = $urandom_range(8, 32);
    p1 = 1'($urandom_range(0, 1)); p2 = 1'($urandom_range(0, 1));
    exp_q.delete();
    model_word(d1, n1, p1);
    model_word(d2, n2, p2);
    fork
      capture();
      begin
        send_word(d1, 6'(n1), p1);
        send_word(d2, 6'(n2), p2);
        checks++; if (tx_ready !== 1'b0) begin errors++; $display("FAIL b2b_ready_held: got %b, required 0", tx_ready); end
        checks++; if (dbg_state !== ST_BIT) begin errors++; $display("FAIL b2b_accept_state: got %0d, required %0d", dbg_state, ST_BIT); end
      end
      begin
        t = 0;
        while (done !== 1'b1 && t < 2000) begin
          @(negedge clk);
          t++;
        end
        repeat (GAP_BITS * BIT_CLKS) @(negedge clk);
        checks++; if (tx_ready !== 1'b0) begin errors++; $display("FAIL b2b_ready_gap_end: got %b, required 0", tx_ready); end
        @(negedge clk);
        checks++; if (tx_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready_second_start: got %b, required 1", tx_ready); end
      end
    join
    checks++;
    if (got_q.size() !== exp_q.size()) begin
      errors++;
      $display("FAIL b2b_len: got %0d busy cycles, required %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL b2b_trace: cycle %0d got {sl0,sl1,busy,done}=%b, required %b", i, got_q[i], exp_q[i]);
        break;
      end
    end
  endtask

  task automatic test_tx_en();
    logic [31:0] d;
    int n, act;
    bit p;
    d = $urandom; n = $urandom_range(8, 32); p = 1'($urandom_range(0, 1));
    tx_en = 1'b0;
    send_word(d, 6'(n), p);
    act = 0;
    repeat (50) begin
      if (busy !== 1'b0 || sl0_o !== 1'b1 || sl1_o !== 1'b1) act++;
      @(negedge clk);
    end
    checks++; if (act !== 0) begin errors++; $display("FAIL txen_hold_idle: got %0d active cycles, required 0", act); end
    checks++; if (tx_ready !== 1'b0) begin errors++; $display("FAIL txen_hold_ready: got %b, required 0", tx_ready); end
    exp_q.delete();
    model_word(d, n, p);
    fork
      capture();
      begin
        tx_en = 1'b1;
        repeat (40) @(negedge clk);
        tx_en = 1'b0;
      end
    join
    tx_en = 1'b1;
    checks++;
    if (got_q.size() !== exp_q.size()) begin
      errors++;
      $display("FAIL txen_len: got %0d busy cycles, required %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL txen_trace: cycle %0d got {sl0,sl1,busy,done}=%b, required %b", i, got_q[i], exp_q[i]);
        break;
      end
    end
  endtask

  task automatic test_reset_mid_word();
    logic [31:0] d;
    int n;
    bit p;
    send_word(32'h0000_003C, 6'd8, 1'b0);
    @(negedge clk);
    repeat (3 * BIT_CLKS + 2) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    checks++; if ({sl0_o, sl1_o} !== 2'b11) begin errors++; $display("FAIL rstmid_lines: got %b, required 11", {sl0_o, sl1_o}); end
    checks++; if (tx_ready !== 1'b1) begin errors++; $display("FAIL rstmid_ready: got %b, required 1", tx_ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b, required 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL rstmid_done: got %b, required 0", done); end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    d = $urandom; n = $urandom_range(8, 32); p = 1'($urandom_range(0, 1));
    exp_q.delete();
    model_word(d, n, p);
    fork
      capture();
      send_word(d, 6'(n), p);
    join
    checks++;
    if (got_q.size() !== exp_q.size()) begin
      errors++;
      $display("FAIL rstmid_len: got %0d busy cycles, required %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL rstmid_trace: cycle %0d got {sl0,sl1,busy,done}=%b, required %b", i, got_q[i], exp_q[i]);
        break;
      end
    end
  endtask

  task automatic test_random_words();
    logic [31:0] d;
    int n;
    bit p;
    for (int w = 0; w < 6; w++) begin
      d = $urandom; n = $urandom_range(8, 32); p = 1'($urandom_range(0, 1));
      exp_q.delete();
      model_word(d, n, p);
      fork
        capture();
        begin
          send_word(d, 6'(n), p);
          // Queued config must not follow later input changes.
          tx_data       = $urandom;
          cfg_bit_cnt   = 6'($urandom_range(0, 63));
          cfg_parity_en = 1'($urandom_range(0, 1));
        end
      join
      checks++;
      if (got_q.size() !== exp_q.size()) begin
        errors++;
        $display("FAIL rand%0d_len: got %0d busy cycles, required %0d", w, got_q.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
        checks++;
        if (got_q[i] !== exp_q[i]) begin
          errors++;
          $display("FAIL rand%0d_trace: n=%0d p=%0d cycle %0d got {sl0,sl1,busy,done}=%b, required %b", w, n, p, i, got_q[i], exp_q[i]);
          break;
        end
      end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_latency();
    test_fixed_words();
    test_len_err();
    test_back_to_back();
    test_tx_en();
    test_reset_mid_word();
    test_random_words();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
